// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and FSM state type for the alu_muldiv execute stage
// Contents: OP_* 4-bit opcodes, state_t (S_IDLE, S_MUL, S_DIV when ALU_MULDIV_DIV_EN)
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_MFHI  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL
`ifdef ALU_MULDIV_DIV_EN
        , S_DIV
`endif
    } state_t;

endpackage

// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - operation/result bundle between pipeline and alu_muldiv
// master: drives in_valid, op, data1, read2, imm, alu_src; sees in_ready and results
// slave:  the ALU; drives in_ready, out_valid, result, zero, hi, lo
interface alu_muldiv_if #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] read2;
    logic [IMM_W-1:0] imm;
    logic             alu_src;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, op, data1, read2, imm, alu_src,
        input  in_ready, out_valid, result, zero, hi, lo
    );

    modport slave (
        input  in_valid, op, data1, read2, imm, alu_src,
        output in_ready, out_valid, result, zero, hi, lo
    );
endinterface

// File: rtl/alu_iter_core.sv
// rtl/alu_iter_core.sv - one-bit-per-cycle shift-add multiplier / restoring divider
// Ports: clk, reset; start loads a/b and the counter; step runs one iteration;
//        is_div (only with ALU_MULDIV_DIV_EN) selects divide; hi_next/lo_next are the
//        values after the current iteration; last flags the final iteration.
module alu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef ALU_MULDIV_DIV_EN
    input  logic             is_div,
`endif
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             last
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // acc: product high half / partial remainder; q: multiplier bits / quotient bits
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] b_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   sum;
`ifdef ALU_MULDIV_DIV_EN
    logic             div_mode;
    logic [WIDTH:0]   shifted;
`endif

    assign last = (cnt == CNT_W'(1));

    always_comb begin
        sum = {1'b0, acc} + {1'b0, b_reg};
        if (q[0]) begin
            {hi_next, lo_next} = {sum, q[WIDTH-1:1]};
        end else begin
            {hi_next, lo_next} = {1'b0, acc, q[WIDTH-1:1]};
        end
`ifdef ALU_MULDIV_DIV_EN
        shifted = {acc, q[WIDTH-1]};
        if (div_mode) begin
            // remainder stays below b, so the W-bit difference is exact
            if (shifted >= {1'b0, b_reg}) begin
                hi_next = shifted[WIDTH-1:0] - b_reg;
                lo_next = {q[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[WIDTH-1:0];
                lo_next = {q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            q     <= '0;
            b_reg <= '0;
            cnt   <= '0;
`ifdef ALU_MULDIV_DIV_EN
            div_mode <= 1'b0;
`endif
        end else if (start) begin
            acc   <= '0;
            q     <= a;
            b_reg <= b;
            cnt   <= CNT_W'(WIDTH);
`ifdef ALU_MULDIV_DIV_EN
            div_mode <= is_div;
`endif
        end else if (step) begin
            acc <= hi_next;
            q   <= lo_next;
            cnt <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - execute-stage ALU with registered result/zero and iterative MULTU/DIVU
// Ports: clk, reset (sync, active-high), bus (alu_muldiv_if.slave)
// Build option: ALU_MULDIV_DIV_EN enables DIVU; otherwise op 1010 behaves as unknown.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
) (
    input logic         clk,
    input logic         reset,
    alu_muldiv_if.slave bus
);
    state_t           state, state_next;
    logic             in_ready;
    logic             accept;
    logic             iter_op;
    logic             core_start;
    logic             core_step;
    logic             core_last;
    logic             commit;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] alu_res;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    assign accept = bus.in_valid & in_ready;
`ifdef ALU_MULDIV_DIV_EN
    assign iter_op = (bus.op == OP_MULTU) || (bus.op == OP_DIVU);
`else
    assign iter_op = (bus.op == OP_MULTU);
`endif

    // Signed size cast gives true sign extension of the immediate
    assign opb = bus.alu_src ? WIDTH'($signed(bus.imm)) : bus.read2;

    always_comb begin
        alu_res = '0;
        case (bus.op)
            OP_AND:  alu_res = bus.data1 & opb;
            OP_OR:   alu_res = bus.data1 | opb;
            OP_ADD:  alu_res = bus.data1 + opb;
            OP_SUB:  alu_res = bus.data1 - opb;
            OP_SLT:  alu_res = WIDTH'($signed(bus.data1) < $signed(opb));
            OP_SLTU: alu_res = WIDTH'(bus.data1 < opb);
            OP_NOR:  alu_res = ~(bus.data1 | opb);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        core_start = 1'b0;
        core_step  = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (accept && bus.op == OP_MULTU) begin
                    state_next = S_MUL;
                    core_start = 1'b1;
`ifdef ALU_MULDIV_DIV_EN
                end else if (accept && bus.op == OP_DIVU) begin
                    state_next = S_DIV;
                    core_start = 1'b1;
`endif
                end
            end
`ifdef ALU_MULDIV_DIV_EN
            S_MUL, S_DIV: begin
`else
            S_MUL: begin
`endif
                core_step = 1'b1;
                // Final iteration result is committed straight from the core's next values
                if (core_last) begin
                    commit     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    alu_iter_core #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .reset   (reset),
        .start   (core_start),
`ifdef ALU_MULDIV_DIV_EN
        .is_div  (bus.op == OP_DIVU),
`endif
        .step    (core_step),
        .a       (bus.data1),
        .b       (opb),
        .hi_next (core_hi),
        .lo_next (core_lo),
        .last    (core_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (commit) begin
                hi_q        <= core_hi;
                lo_q        <= core_lo;
                result_q    <= core_lo;
                zero_q      <= (core_lo == '0);
                out_valid_q <= 1'b1;
            end else if (accept && !iter_op) begin
                result_q    <= alu_res;
                zero_q      <= (alu_res == '0);
                out_valid_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule
